// File: rtl/matvec_mult_lanes.sv
// rtl/matvec_mult_lanes.sv - P-lane signed fixed-point matrix-vector multiplier (y = W*x)
// Optional macro ACC_SAT_EN: saturate results to DATA_W instead of wrapping.
module matvec_mult_lanes #(
  parameter int P           = 4,
  parameter int LENGTH_N    = 32,
  parameter int LENGTH_M    = 512,
  parameter int DATA_W      = 16,
  parameter int FRAC_BITS   = 8,
  parameter int ADDR_W_SIZE = 15,
  parameter int ADDR_X_SIZE = 12,
  parameter int ADDR_Y_SIZE = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              ps_control,
  output logic [31:0]              pl_status,
  output logic [31:0]              state,
  output logic [P*ADDR_W_SIZE-1:0] bram_addr_W,
  input  logic [P*32-1:0]          bram_rddata_W,
  output logic [P*4-1:0]           bram_we_W,
  output logic [ADDR_X_SIZE-1:0]   bram_addr_x,
  input  logic [31:0]              bram_rddata_x,
  output logic [3:0]               bram_we_x,
  output logic [P*ADDR_Y_SIZE-1:0] bram_addr_y,
  output logic [P*32-1:0]          bram_wrdata_y,
  output logic [P*4-1:0]           bram_we_y
);

  localparam int GROUPS = LENGTH_M / P;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 2 * DATA_W + $clog2(LENGTH_N);
  localparam int J_W    = (LENGTH_N > 1) ? $clog2(LENGTH_N) : 1;
  localparam int G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [J_W-1:0] J_LAST = J_W'(LENGTH_N - 1);
  localparam logic [G_W-1:0] G_LAST = G_W'(GROUPS - 1);

  if (P < 1 || P > 8) begin : g_bad_p
    $error("matvec_mult_lanes: P must be in 1..8");
  end
  if (LENGTH_M % P != 0) begin : g_bad_m
    $error("matvec_mult_lanes: LENGTH_M must be a multiple of P");
  end
  if (DATA_W < 2 || DATA_W > 32) begin : g_bad_dw
    $error("matvec_mult_lanes: DATA_W must be in 2..32");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t   state_q, state_d;
  logic [J_W-1:0] j_q, j_d;
  logic [G_W-1:0] g_q, g_d;
  logic     drain_q, drain_d;
  logic     done_q, done_d;
  logic     aborted_q, aborted_d;
  logic     valid1_q, valid1_d;
  logic     valid2_q, valid2_d;
  logic signed [PROD_W-1:0] prod_q [P];
  logic signed [PROD_W-1:0] prod_d [P];
  logic signed [ACC_W-1:0]  acc_q  [P];
  logic signed [ACC_W-1:0]  acc_d  [P];

  logic start;
  assign start = ps_control[0];

  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    g_d       = g_q;
    drain_d   = drain_q;
    aborted_d = aborted_q;
    case (state_q)
      S_IDLE: begin
        j_d = '0;
        g_d = '0;
        if (start) begin
          state_d   = S_CLEAR;
          aborted_d = 1'b0;
        end
      end
      S_CLEAR: begin
        if (!start) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else begin
          state_d = S_ISSUE;
          j_d     = '0;
        end
      end
      S_ISSUE: begin
        if (!start) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (j_q == J_LAST) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          j_d = j_q + J_W'(1);
        end
      end
      S_DRAIN: begin
        if (!start) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (drain_q) begin
          state_d = S_WRITE;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_WRITE: begin
        // The write strobe is asserted for this whole cycle even if start drops.
        if (!start) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (g_q == G_LAST) begin
          state_d = S_DONE;
        end else begin
          g_d     = g_q + G_W'(1);
          state_d = S_CLEAR;
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
  end

  logic signed [DATA_W-1:0] x_s;
  logic signed [DATA_W-1:0] w_s [P];

  always_comb begin
    x_s      = bram_rddata_x[DATA_W-1:0];
    valid1_d = (state_q == S_ISSUE) && start;
    valid2_d = valid1_q;
    for (int p = 0; p < P; p++) begin
      w_s[p]    = bram_rddata_W[p*32 +: DATA_W];
      prod_d[p] = PROD_W'(w_s[p]) * PROD_W'(x_s);
      acc_d[p]  = acc_q[p];
      // Clearing in IDLE also discards products still in flight after an abort.
      if (state_q == S_IDLE || state_q == S_CLEAR) begin
        acc_d[p] = '0;
      end else if (valid2_q) begin
        acc_d[p] = acc_q[p] + ACC_W'(prod_q[p]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      j_q       <= '0;
      g_q       <= '0;
      drain_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      valid1_q  <= 1'b0;
      valid2_q  <= 1'b0;
      for (int p = 0; p < P; p++) begin
        prod_q[p] <= '0;
        acc_q[p]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      g_q       <= g_d;
      drain_q   <= drain_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      valid1_q  <= valid1_d;
      valid2_q  <= valid2_d;
      for (int p = 0; p < P; p++) begin
        prod_q[p] <= prod_d[p];
        acc_q[p]  <= acc_d[p];
      end
    end
  end

  logic [31:0] w_word;
  logic [31:0] x_word;
  logic [31:0] y_word;
  logic        we_y;

  always_comb begin
    w_word = 32'(g_q) * 32'(LENGTH_N) + 32'(j_q);
    x_word = 32'(j_q);
    y_word = 32'(g_q);
    we_y   = (state_q == S_WRITE);
  end

  assign state       = {29'b0, state_q};
  assign pl_status   = {30'b0, aborted_q, done_q};
  assign bram_addr_x = ADDR_X_SIZE'({x_word[29:0], 2'b00});
  assign bram_we_x   = 4'h0;
  assign bram_we_W   = '0;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  for (genvar p = 0; p < P; p++) begin : g_lane
    logic signed [ACC_W-1:0]  shifted;
    logic signed [DATA_W-1:0] res;

    always_comb begin
      shifted = acc_q[p] >>> FRAC_BITS;
`ifdef ACC_SAT_EN
      if (shifted > SAT_MAX) begin
        res = SAT_MAX[DATA_W-1:0];
      end else if (shifted < SAT_MIN) begin
        res = SAT_MIN[DATA_W-1:0];
      end else begin
        res = shifted[DATA_W-1:0];
      end
`else
      res = shifted[DATA_W-1:0];
`endif
    end

    assign bram_addr_W[p*ADDR_W_SIZE +: ADDR_W_SIZE] = ADDR_W_SIZE'({w_word[29:0], 2'b00});
    assign bram_addr_y[p*ADDR_Y_SIZE +: ADDR_Y_SIZE] = ADDR_Y_SIZE'({y_word[29:0], 2'b00});
    assign bram_wrdata_y[p*32 +: 32] = 32'(res);
    assign bram_we_y[p*4 +: 4]       = we_y ? 4'hF : 4'h0;

    logic unused_shift;
    assign unused_shift = ^shifted;
  end

  logic unused_inputs;
  assign unused_inputs = ^{ps_control, bram_rddata_W, bram_rddata_x, w_word, x_word, y_word,
                           SAT_MAX, SAT_MIN};

endmodule

// File: tb/tb_matvec_mult_lanes.sv
// tb/tb_matvec_mult_lanes.sv - self-checking bench for matvec_mult_lanes
// Drives BRAM models and compares captured y writes with a dot-product reference.
module tb_matvec_mult_lanes;
  localparam int P    = 2;
  localparam int N    = 4;
  localparam int M    = 4;
  localparam int G    = M / P;
  localparam int DW   = 16;
  localparam int FRAC = 8;
  localparam int AW   = 15;
  localparam int AX   = 12;
  localparam int AY   = 12;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [31:0]       ps_control = 32'd0;
  logic [31:0]       pl_status;
  logic [31:0]       state;
  logic [P*AW-1:0]   bram_addr_W;
  logic [P*32-1:0]   rd_W = '0;
  logic [P*4-1:0]    bram_we_W;
  logic [AX-1:0]     bram_addr_x;
  logic [31:0]       rd_x = '0;
  logic [3:0]        bram_we_x;
  logic [P*AY-1:0]   bram_addr_y;
  logic [P*32-1:0]   bram_wrdata_y;
  logic [P*4-1:0]    bram_we_y;

  matvec_mult_lanes #(
    .P(P), .LENGTH_N(N), .LENGTH_M(M), .DATA_W(DW), .FRAC_BITS(FRAC),
    .ADDR_W_SIZE(AW), .ADDR_X_SIZE(AX), .ADDR_Y_SIZE(AY)
  ) dut (
    .clk(clk), .reset(reset), .ps_control(ps_control), .pl_status(pl_status),
    .state(state), .bram_addr_W(bram_addr_W), .bram_rddata_W(rd_W),
    .bram_we_W(bram_we_W), .bram_addr_x(bram_addr_x), .bram_rddata_x(rd_x),
    .bram_we_x(bram_we_x), .bram_addr_y(bram_addr_y), .bram_wrdata_y(bram_wrdata_y),
    .bram_we_y(bram_we_y)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          wg [M][N];
  int          xv [N];
  logic [31:0] wmem [P][G*N];
  logic [31:0] xmem [N];
  logic [31:0] ycap [P][G];
  int          wcnt [P][G];
  int          bad_we = 0;
  int          stray = 0;
  int          total_writes = 0;

  // Synchronous-read BRAMs with one cycle of latency.
  always @(posedge clk) begin
    for (int p = 0; p < P; p++) begin
      rd_W[p*32 +: 32] <= wmem[p][(int'(bram_addr_W[p*AW +: AW]) >> 2) % (G*N)];
    end
    rd_x <= xmem[(int'(bram_addr_x) >> 2) % N];
  end

  always @(negedge clk) begin
    for (int p = 0; p < P; p++) begin
      if (bram_we_y[p*4 +: 4] != 4'h0) begin
        int gi;
        total_writes++;
        if (bram_we_y[p*4 +: 4] != 4'hF) bad_we++;
        gi = int'(bram_addr_y[p*AY +: AY]) >> 2;
        if (gi < G && (bram_addr_y[p*AY +: 2] == 2'b00)) begin
          ycap[p][gi] = bram_wrdata_y[p*32 +: 32];
          wcnt[p][gi]++;
        end else begin
          stray++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ref_y(input int r);
    longint acc;
    acc = 0;
    for (int j = 0; j < N; j++) acc += longint'(wg[r][j]) * longint'(xv[j]);
    acc = acc >>> FRAC;
`ifdef ACC_SAT_EN
    if (acc > 32767) return 32767;
    if (acc < -32768) return -32768;
    return int'(acc);
`else
    return int'(shortint'(acc[15:0]));
`endif
  endfunction

  task automatic load_mem();
    for (int r = 0; r < M; r++) begin
      for (int j = 0; j < N; j++) begin
        logic [15:0] junk;
        junk = 16'($urandom);
        wmem[r % P][(r / P) * N + j] = {junk, 16'(wg[r][j])};
      end
    end
    for (int j = 0; j < N; j++) xmem[j] = {16'($urandom), 16'(xv[j])};
  endtask

  task automatic clear_caps();
    for (int p = 0; p < P; p++)
      for (int g = 0; g < G; g++) begin
        ycap[p][g] = 32'hDEADBEEF;
        wcnt[p][g] = 0;
      end
    bad_we = 0;
    stray  = 0;
  endtask

  task automatic run_check(input string name);
    int n;
    clear_caps();
    @(negedge clk);
    ps_control = 32'd1;
    @(posedge clk);
    @(negedge clk);
    check({name, "_leave_idle_state"}, state, 32'd1);
    check({name, "_leave_idle_status"}, pl_status, 32'd0);
    n = 1;
    while (n < 300 && pl_status[0] !== 1'b1) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({name, "_cycles_to_done"}, 32'(n), 32'(G * (N + 4) + 1));
    check({name, "_done_status"}, pl_status, 32'd1);
    for (int r = 0; r < M; r++)
      check($sformatf("%s_y_r%0d", name, r), ycap[r % P][r / P], 32'(ref_y(r)));
    for (int p = 0; p < P; p++)
      for (int g = 0; g < G; g++)
        check($sformatf("%s_wcnt_p%0d_g%0d", name, p, g), 32'(wcnt[p][g]), 32'd1);
    check({name, "_bad_we"}, 32'(bad_we), 32'd0);
    check({name, "_stray"}, 32'(stray), 32'd0);
  endtask

  task automatic finish_run(input string name);
    @(negedge clk);
    ps_control = 32'd0;
    @(posedge clk);
    @(negedge clk);
    check({name, "_drop_state"}, state, 32'd0);
    check({name, "_drop_status"}, pl_status, 32'd0);
  endtask

  task automatic randomize_data();
    for (int r = 0; r < M; r++)
      for (int j = 0; j < N; j++) wg[r][j] = int'($urandom_range(0, 65535)) - 32768;
    for (int j = 0; j < N; j++) xv[j] = int'($urandom_range(0, 65535)) - 32768;
    load_mem();
  endtask

  initial begin
    int n;
    int hold_bad;
    int snap;
    logic [31:0] exp_ovf;

    for (int r = 0; r < M; r++) for (int j = 0; j < N; j++) wg[r][j] = 0;
    for (int j = 0; j < N; j++) xv[j] = 0;
    load_mem();
    clear_caps();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", state, 32'd0);
    check("rst_status", pl_status, 32'd0);
    check("rst_we_y", 32'(bram_we_y), 32'd0);
    check("rst_addr_W", 32'(bram_addr_W), 32'd0);
    check("rst_addr_y", 32'(bram_addr_y), 32'd0);
    check("rst_wrdata", bram_wrdata_y[31:0] | bram_wrdata_y[63:32], 32'd0);
    check("rst_we_W_x", {24'd0, bram_we_W, bram_we_x}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Identity: x scaled by 2^FRAC so y reads back as plain integers
    for (int r = 0; r < M; r++) for (int j = 0; j < N; j++) wg[r][j] = (r == j) ? 1 : 0;
    for (int j = 0; j < N; j++) xv[j] = (j + 1) * 256;
    load_mem();
    run_check("ident");
    check("ident_l0_a0", ycap[0][0], 32'd1);
    check("ident_l0_a4", ycap[0][1], 32'd3);
    check("ident_l1_a0", ycap[1][0], 32'd2);
    check("ident_l1_a4", ycap[1][1], 32'd4);

    // Start held after DONE must not restart
    hold_bad = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (state !== 32'd5 || pl_status !== 32'd1) hold_bad++;
    end
    check("hold_done", 32'(hold_bad), 32'd0);
    finish_run("ident");

    // Signed mixed
    for (int r = 0; r < M; r++) for (int j = 0; j < N; j++) wg[r][j] = -3;
    xv[0] = 5 * 256; xv[1] = -256; xv[2] = 2 * 256; xv[3] = 7 * 256;
    load_mem();
    run_check("signed");
    for (int p = 0; p < P; p++)
      for (int g = 0; g < G; g++)
        check($sformatf("signed_const_p%0d_g%0d", p, g), ycap[p][g], 32'hFFFFFFD9);
    finish_run("signed");

    // Fractional / overflow
    for (int r = 0; r < M; r++) for (int j = 0; j < N; j++) wg[r][j] = 32'h7FFF;
    for (int j = 0; j < N; j++) xv[j] = 32'h7FFF;
    load_mem();
    run_check("ovf");
`ifdef ACC_SAT_EN
    exp_ovf = 32'h00007FFF;
`else
    exp_ovf = 32'hFFFFFC00;
`endif
    check("ovf_const_l0", ycap[0][0], exp_ovf);
    check("ovf_const_l1", ycap[1][1], exp_ovf);
    finish_run("ovf");

    // Random datasets
    for (int k = 0; k < 3; k++) begin
      randomize_data();
      run_check($sformatf("rand%0d", k));
      finish_run($sformatf("rand%0d", k));
    end

    // Abort mid-ISSUE of group 1
    randomize_data();
    clear_caps();
    @(negedge clk);
    ps_control = 32'd1;
    n = 0;
    while (n < 200 && !(state == 32'd2 && bram_addr_y[AY-1:0] == 12'd4)) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("abort_reach_g1", 32'(n < 200), 32'd1);
    @(posedge clk);
    @(negedge clk);
    ps_control = 32'd0;
    @(posedge clk);
    @(negedge clk);
    check("abort_state", state, 32'd0);
    check("abort_status", pl_status, 32'd2);
    repeat (20) @(negedge clk);
    check("abort_status_held", pl_status, 32'd2);
    for (int p = 0; p < P; p++) begin
      check($sformatf("abort_g0_wcnt_p%0d", p), 32'(wcnt[p][0]), 32'd1);
      check($sformatf("abort_g0_y_p%0d", p), ycap[p][0], 32'(ref_y(p)));
      check($sformatf("abort_g1_wcnt_p%0d", p), 32'(wcnt[p][1]), 32'd0);
    end
    run_check("restart");
    finish_run("restart");

    // Async reset mid-DRAIN
    randomize_data();
    @(negedge clk);
    ps_control = 32'd1;
    n = 0;
    while (n < 200 && state != 32'd3) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("areset_reach_drain", 32'(n < 200), 32'd1);
    #2;
    reset = 1'b0;
    ps_control = 32'd0;
    #1;
    check("areset_state", state, 32'd0);
    check("areset_status", pl_status, 32'd0);
    check("areset_we_y", 32'(bram_we_y), 32'd0);
    check("areset_addr_W", 32'(bram_addr_W), 32'd0);
    check("areset_addr_x", 32'(bram_addr_x), 32'd0);
    check("areset_wrdata", bram_wrdata_y[31:0] | bram_wrdata_y[63:32], 32'd0);
    snap = total_writes;
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("areset_no_write", 32'(total_writes), 32'(snap));
    check("areset_idle", state, 32'd0);

    randomize_data();
    run_check("post_reset");
    finish_run("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
